// File: rtl/rcb_spi_master.sv
// ---------------------------------------------------------------------------
// rcb_spi_master
//
// Purpose:
//   SPI master (mode 0, MSB first) that issues one 40-bit register frame per
//   request to the RCB SPI slave port. Frame word is
//   {req_rd, req_addr[6:0], req_wdata[31:0]}, with bit 39 sent first. The
//   miso bits captured during the last 32 sclk periods are returned on
//   rsp_rdata together with a one-cycle rsp_valid pulse when the frame ends.
//
// Parameters:
//   CLK_DIV : clk_100m cycles per sclk half-period (4..255, 50 -> 1 MHz)
//   CS_GAP  : clk_100m cycles cs_n is held high after a frame (1..255)
//
// Ports:
//   clk_100m   in   system clock
//   rst_n      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle when req_valid is also high
//   req_rd     in   1 = read, 0 = write (transmitted as frame bit 39)
//   req_addr   in   7-bit register address
//   req_wdata  in   32-bit write data (shifted out for reads as well)
//   rsp_valid  out  one-cycle pulse at frame completion
//   rsp_rdata  out  miso data of the 32 data bits, held until next pulse
//   busy       out  inverse of req_ready
//   sclk       out  SPI clock, idle low
//   cs_n       out  SPI chip select, active low
//   mosi       out  SPI master out
//   miso       in   SPI master in, asynchronous to clk_100m
// ---------------------------------------------------------------------------
module rcb_spi_master #(
  parameter int unsigned CLK_DIV = 50,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic        clk_100m,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic [6:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);
  localparam logic [5:0] FRAME_BITS = 6'd40;

  state_t      r_state;
  logic [7:0]  r_div_cnt;   // phase length counter, also times the GAP state
  logic [5:0]  r_bit_cnt;   // falling edges still to come in this frame
  // Bits 38..0 of the frame still to be sent. Bit 39 goes straight to mosi
  // at accept, so it never needs to be stored here.
  logic [38:0] r_shift;
  // Only the last 32 captured bits (the data phase) are ever reported, so the
  // 8 command-phase bits simply fall off the top of this register.
  logic [31:0] r_cap;
  logic        r_miso_s1;
  logic        r_miso_s2;
  logic        r_req_ready;
  logic        r_busy;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_sclk;
  logic        r_cs_n;
  logic        r_mosi;

  // Two-flop synchronizer bringing miso into the clk_100m domain.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      r_miso_s1 <= 1'b0;
      r_miso_s2 <= 1'b0;
    end else begin
      r_miso_s1 <= miso;
      r_miso_s2 <= r_miso_s1;
    end
  end

  // Frame sequencer: state, counters, shift/capture registers and all outputs.
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_div_cnt   <= 8'd0;
      r_bit_cnt   <= 6'd0;
      r_shift     <= 39'd0;
      r_cap       <= 32'd0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_sclk      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
    end else begin
      // rsp_valid is a single-cycle pulse; only the HOLD exit raises it.
      r_rsp_valid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_sclk <= 1'b0;
          r_cs_n <= 1'b1;
          // req_ready is always high in IDLE, so req_valid alone is an accept.
          if (req_valid) begin
            r_shift     <= {req_addr, req_wdata};
            r_mosi      <= req_rd;
            r_cs_n      <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_div_cnt   <= DIV_RELOAD;
            r_bit_cnt   <= FRAME_BITS;
            r_state     <= ST_SETUP;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_SETUP: begin
          if (r_div_cnt == 8'd0) begin
            r_sclk    <= 1'b1;
            r_div_cnt <= DIV_RELOAD;
            r_state   <= ST_SHIFT;
          end else begin
            r_div_cnt <= r_div_cnt - 8'd1;
          end
        end

        ST_SHIFT: begin
          if (r_div_cnt != 8'd0) begin
            r_div_cnt <= r_div_cnt - 8'd1;
          end else if (r_sclk) begin
            // Last cycle of the high phase: sample miso, then drop sclk.
            r_cap     <= {r_cap[30:0], r_miso_s2};
            r_sclk    <= 1'b0;
            r_div_cnt <= DIV_RELOAD;
            r_bit_cnt <= r_bit_cnt - 6'd1;
            // The 40th falling edge has no next bit to present.
            if (r_bit_cnt != 6'd1) begin
              r_mosi  <= r_shift[38];
              r_shift <= {r_shift[37:0], 1'b0};
            end else begin
              r_mosi  <= r_mosi;
            end
          end else begin
            // End of a low phase: either start the next period or finish.
            r_div_cnt <= DIV_RELOAD;
            if (r_bit_cnt == 6'd0) begin
              r_state <= ST_HOLD;
            end else begin
              r_sclk <= 1'b1;
            end
          end
        end

        ST_HOLD: begin
          if (r_div_cnt == 8'd0) begin
            r_cs_n      <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_cap;
            r_div_cnt   <= GAP_RELOAD;
            r_state     <= ST_GAP;
          end else begin
            r_div_cnt <= r_div_cnt - 8'd1;
          end
        end

        ST_GAP: begin
          if (r_div_cnt == 8'd0) begin
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt - 8'd1;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_div_cnt   <= 8'd0;
          r_bit_cnt   <= 6'd0;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_sclk      <= 1'b0;
          r_cs_n      <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign sclk      = r_sclk;
  assign cs_n      = r_cs_n;
  assign mosi      = r_mosi;

endmodule

// File: tb/tb_rcb_spi_master.sv
`timescale 1ns/1ps
module tb_rcb_spi_master;

  localparam int CD_A = 50;
  localparam int CD_B = 4;
  localparam int GAP  = 8;

  logic clk_100m = 1'b0;
  always #5 clk_100m = ~clk_100m;

  logic        rst_n = 1'b0;
  // DUT A: default divider
  logic        req_valid = 1'b0, req_rd = 1'b0;
  logic [6:0]  req_addr = 7'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, rsp_valid, busy, sclk, cs_n, mosi;
  logic [31:0] rsp_rdata;
  logic        miso = 1'b0;
  // DUT B: CLK_DIV = 4
  logic        req_valid_b = 1'b0, req_rd_b = 1'b0;
  logic [6:0]  req_addr_b = 7'd0;
  logic [31:0] req_wdata_b = 32'd0;
  logic        req_ready_b, rsp_valid_b, busy_b, sclk_b, cs_n_b, mosi_b;
  logic [31:0] rsp_rdata_b;
  logic        miso_b = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  rcb_spi_master #(.CLK_DIV(CD_A), .CS_GAP(GAP)) u_dut (
    .clk_100m(clk_100m), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .busy(busy), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso));

  rcb_spi_master #(.CLK_DIV(CD_B), .CS_GAP(GAP)) u_dut_b (
    .clk_100m(clk_100m), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_rd(req_rd_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .busy(busy_b), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b));

  // ---------------- slave models / receivers ----------------
  logic [39:0] slv_word_a = 40'd0, slv_word_b = 40'd0;
  logic [39:0] rx_a = 40'd0, rx_b = 40'd0;
  int rise_a = 0, rise_b = 0, last_rise_a = 0, last_rise_b = 0;
  int cs_fall_a = 0;

  // Receive mosi on sclk rises; cs_n rising closes the frame.
  always @(posedge sclk or posedge cs_n) begin
    if (cs_n === 1'b1) begin
      if (rise_a != 0) last_rise_a = rise_a;
      rise_a = 0;
    end else begin
      rx_a = {rx_a[38:0], mosi};
      rise_a++;
    end
  end
  always @(posedge sclk_b or posedge cs_n_b) begin
    if (cs_n_b === 1'b1) begin
      if (rise_b != 0) last_rise_b = rise_b;
      rise_b = 0;
    end else begin
      rx_b = {rx_b[38:0], mosi_b};
      rise_b++;
    end
  end
  // Mode-0 slave: first bit on cs_n fall, next bit on every sclk fall.
  always @(negedge sclk or negedge cs_n) begin
    if (cs_n === 1'b0 && rise_a < 40) miso = slv_word_a[6'(39 - rise_a)];
    else miso = 1'b0;
  end
  always @(negedge sclk_b or negedge cs_n_b) begin
    if (cs_n_b === 1'b0 && rise_b < 40) miso_b = slv_word_b[6'(39 - rise_b)];
    else miso_b = 1'b0;
  end
  always @(negedge cs_n) cs_fall_a++;

  // ---------------- protocol invariant monitors ----------------
  logic mon_en = 1'b0;
  int viol_a = 0, viol_b = 0, rsp_cnt_a = 0, rsp_cnt_b = 0;
  logic mosi_prev_a = 1'b0, mosi_prev_b = 1'b0, rsp_prev_a = 1'b0, rsp_prev_b = 1'b0;
  always @(negedge clk_100m) begin
    if (mon_en) begin
      if (sclk === 1'b1 && mosi !== mosi_prev_a) viol_a++;
      if (cs_n === 1'b1 && sclk !== 1'b0) viol_a++;
      if (busy !== !req_ready) viol_a++;
      if (rsp_valid === 1'b1 && (req_ready === 1'b1 || rsp_prev_a === 1'b1)) viol_a++;
      if (sclk_b === 1'b1 && mosi_b !== mosi_prev_b) viol_b++;
      if (cs_n_b === 1'b1 && sclk_b !== 1'b0) viol_b++;
      if (busy_b !== !req_ready_b) viol_b++;
      if (rsp_valid_b === 1'b1 && (req_ready_b === 1'b1 || rsp_prev_b === 1'b1)) viol_b++;
    end
    if (rsp_valid === 1'b1) rsp_cnt_a++;
    if (rsp_valid_b === 1'b1) rsp_cnt_b++;
    mosi_prev_a = mosi;
    mosi_prev_b = mosi_b;
    rsp_prev_a  = rsp_valid;
    rsp_prev_b  = rsp_valid_b;
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic wait_ready(input bit use_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if ((use_b ? req_ready_b : req_ready) === 1'b1) ok = 1'b1;
      else @(negedge clk_100m);
    end
  endtask

  // Issues one request and follows the frame until cs_n returns high.
  task automatic run_frame(input bit use_b, input logic rd, input logic [6:0] addr,
                           input logic [31:0] wd, output int low_cyc, output int first_hi,
                           output int hi_cyc, output logic pulse, output logic [31:0] rdata);
    @(negedge clk_100m);
    if (use_b) begin
      req_rd_b = rd; req_addr_b = addr; req_wdata_b = wd; req_valid_b = 1'b1;
    end else begin
      req_rd = rd; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    end
    @(negedge clk_100m);
    req_valid = 1'b0;
    req_valid_b = 1'b0;
    low_cyc = 0; first_hi = 0; hi_cyc = 0;
    while (((use_b ? cs_n_b : cs_n) === 1'b0) && low_cyc < 6000) begin
      low_cyc++;
      if ((use_b ? sclk_b : sclk) === 1'b1) begin
        hi_cyc++;
        if (first_hi == 0) first_hi = low_cyc;
      end
      @(negedge clk_100m);
    end
    pulse = use_b ? rsp_valid_b : rsp_valid;
    rdata = use_b ? rsp_rdata_b : rsp_rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100m);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if ({sclk, cs_n, mosi} !== 3'b010) begin n_err++; $display("FAIL rst_spi_pins: got sclk/cs_n/mosi=%b want 010", {sclk, cs_n, mosi}); end
    n_vec++; if ({req_ready_b, sclk_b, cs_n_b} !== 3'b101) begin n_err++; $display("FAIL rst_dut_b: got ready/sclk/cs_n=%b want 101", {req_ready_b, sclk_b, cs_n_b}); end
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk_100m);
  endtask

  task automatic test_write();
    int lc, fh, hc; logic p; logic [31:0] rd; bit ok; int r0;
    slv_word_a = 40'h00_0000_0000;
    r0 = rsp_cnt_a;
    run_frame(1'b0, 1'b0, 7'h12, 32'hA5A5_0F0F, lc, fh, hc, p, rd);
    n_vec++; if (lc != 82 * CD_A) begin n_err++; $display("FAIL wr_cs_low_cycles: got %0d want %0d", lc, 82 * CD_A); end
    n_vec++; if (fh != CD_A + 1) begin n_err++; $display("FAIL wr_first_rise: got %0d want %0d", fh, CD_A + 1); end
    n_vec++; if (hc != 40 * CD_A) begin n_err++; $display("FAIL wr_sclk_high_cycles: got %0d want %0d", hc, 40 * CD_A); end
    n_vec++; if (p !== 1'b1) begin n_err++; $display("FAIL wr_rsp_at_cs_rise: got %b want 1", p); end
    n_vec++; if (rx_a !== 40'h12_A5A5_0F0F) begin n_err++; $display("FAIL wr_mosi_frame: got %h want 12a5a50f0f", rx_a); end
    n_vec++; if (last_rise_a != 40) begin n_err++; $display("FAIL wr_rise_count: got %0d want 40", last_rise_a); end
    n_vec++; if (rd !== 32'd0) begin n_err++; $display("FAIL wr_rdata: got %h want 0", rd); end
    wait_ready(1'b0, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wr_ready_timeout: got timeout want ready"); end
    n_vec++; if (rsp_cnt_a - r0 != 1) begin n_err++; $display("FAIL wr_rsp_pulses: got %0d want 1", rsp_cnt_a - r0); end
  endtask

  task automatic test_read();
    int lc, fh, hc; logic p; logic [31:0] rd; bit ok;
    slv_word_a = {8'h3C, 32'hDEAD_BEEF};
    run_frame(1'b0, 1'b1, 7'h05, 32'h0000_0000, lc, fh, hc, p, rd);
    n_vec++; if (rx_a[39] !== 1'b1) begin n_err++; $display("FAIL rd_bit39: got %b want 1", rx_a[39]); end
    n_vec++; if (rx_a !== 40'h85_0000_0000) begin n_err++; $display("FAIL rd_mosi_frame: got %h want 8500000000", rx_a); end
    n_vec++; if (p !== 1'b1) begin n_err++; $display("FAIL rd_rsp_pulse: got %b want 1", p); end
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_rdata: got %h want deadbeef", rd); end
    wait_ready(1'b0, ok);
    repeat (20) @(negedge clk_100m);
    n_vec++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_rdata_held: got %h want deadbeef", rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    int acc_t[2]; int n_acc; int rsp_t; int r0, f0; bit ok;
    slv_word_a = 40'd0;
    r0 = rsp_cnt_a; f0 = cs_fall_a;
    n_acc = 0; rsp_t = -1; acc_t[0] = 0; acc_t[1] = 0;
    @(negedge clk_100m);
    req_rd = 1'b0; req_addr = 7'h11; req_wdata = 32'h0102_0304; req_valid = 1'b1;
    for (int i = 0; i < 9000 && n_acc < 2; i++) begin
      if (req_ready === 1'b1) begin acc_t[n_acc] = i; n_acc++; end
      if (rsp_valid === 1'b1 && rsp_t < 0) rsp_t = i;
      @(negedge clk_100m);
    end
    req_valid = 1'b0;
    n_vec++; if (n_acc != 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", n_acc); end
    n_vec++; if (acc_t[1] - acc_t[0] != 82 * CD_A + 1 + GAP) begin n_err++; $display("FAIL b2b_accept_spacing: got %0d want %0d", acc_t[1] - acc_t[0], 82 * CD_A + 1 + GAP); end
    n_vec++; if (acc_t[1] - rsp_t != GAP) begin n_err++; $display("FAIL b2b_gap_state: got %0d want %0d", acc_t[1] - rsp_t, GAP); end
    // A request raised mid-frame must be ignored once dropped again.
    repeat (100) @(negedge clk_100m);
    req_valid = 1'b1;
    repeat (10) @(negedge clk_100m);
    req_valid = 1'b0;
    for (int i = 0; i < 6000 && rsp_valid !== 1'b1; i++) @(negedge clk_100m);
    wait_ready(1'b0, ok);
    repeat (300) @(negedge clk_100m);
    n_vec++; if (rsp_cnt_a - r0 != 2) begin n_err++; $display("FAIL b2b_rsp_count: got %0d want 2", rsp_cnt_a - r0); end
    n_vec++; if (cs_fall_a - f0 != 2) begin n_err++; $display("FAIL b2b_frame_count: got %0d want 2", cs_fall_a - f0); end
    n_vec++; if (rx_a !== 40'h11_0102_0304) begin n_err++; $display("FAIL b2b_mosi_frame: got %h want 1101020304", rx_a); end
  endtask

  task automatic test_reset_midframe();
    int rises, r0; logic prev; int lc, fh, hc; logic p; logic [31:0] rd;
    slv_word_a = 40'd0;
    r0 = rsp_cnt_a;
    @(negedge clk_100m);
    req_rd = 1'b1; req_addr = 7'h7F; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
    @(negedge clk_100m);
    req_valid = 1'b0;
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 3000 && rises < 20; i++) begin
      @(negedge clk_100m);
      if (sclk === 1'b1 && prev !== 1'b1) rises++;
      prev = sclk;
    end
    n_vec++; if (rises != 20 || mosi !== 1'b1) begin n_err++; $display("FAIL rstmf_reach_rise20: got rises=%0d mosi=%b want 20/1", rises, mosi); end
    rst_n = 1'b0;
    @(negedge clk_100m);
    n_vec++; if ({cs_n, sclk, mosi} !== 3'b100) begin n_err++; $display("FAIL rstmf_pins: got cs_n/sclk/mosi=%b want 100", {cs_n, sclk, mosi}); end
    n_vec++; if ({req_ready, busy, rsp_valid} !== 3'b100) begin n_err++; $display("FAIL rstmf_handshake: got ready/busy/rsp=%b want 100", {req_ready, busy, rsp_valid}); end
    n_vec++; if (rsp_rdata !== 32'd0) begin n_err++; $display("FAIL rstmf_rdata: got %h want 0", rsp_rdata); end
    repeat (2) @(negedge clk_100m);
    rst_n = 1'b1;
    repeat (300) @(negedge clk_100m);
    n_vec++; if (rsp_cnt_a != r0) begin n_err++; $display("FAIL rstmf_no_rsp: got %0d pulses want 0", rsp_cnt_a - r0); end
    slv_word_a = {8'h00, 32'hCAFE_F00D};
    run_frame(1'b0, 1'b0, 7'h3C, 32'h0F1E_2D3C, lc, fh, hc, p, rd);
    n_vec++; if (lc != 82 * CD_A) begin n_err++; $display("FAIL rstmf_clean_low: got %0d want %0d", lc, 82 * CD_A); end
    n_vec++; if (rx_a !== 40'h3C_0F1E_2D3C || last_rise_a != 40) begin n_err++; $display("FAIL rstmf_clean_frame: got %h/%0d want 3c0f1e2d3c/40", rx_a, last_rise_a); end
    n_vec++; if (p !== 1'b1 || rd !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rstmf_clean_rsp: got %b/%h want 1/cafef00d", p, rd); end
  endtask

  task automatic test_clkdiv4();
    int lc, fh, hc; logic p; logic [31:0] rd; bit ok;
    slv_word_b = {8'hC3, 32'h1234_5678};
    wait_ready(1'b1, ok);
    run_frame(1'b1, 1'b0, 7'h40, 32'h8765_4321, lc, fh, hc, p, rd);
    n_vec++; if (lc != 82 * CD_B) begin n_err++; $display("FAIL div4_cs_low: got %0d want %0d", lc, 82 * CD_B); end
    n_vec++; if (fh != CD_B + 1 || hc != 40 * CD_B) begin n_err++; $display("FAIL div4_sclk_timing: got first=%0d high=%0d want %0d/%0d", fh, hc, CD_B + 1, 40 * CD_B); end
    n_vec++; if (p !== 1'b1 || rd !== 32'h1234_5678) begin n_err++; $display("FAIL div4_rdata: got %b/%h want 1/12345678", p, rd); end
    n_vec++; if (rx_b !== 40'h40_8765_4321 || last_rise_b != 40) begin n_err++; $display("FAIL div4_mosi_frame: got %h/%0d want 4087654321/40", rx_b, last_rise_b); end
    wait_ready(1'b1, ok);
    n_vec++; if (!ok || rsp_cnt_b != 1) begin n_err++; $display("FAIL div4_complete: got ready=%b pulses=%0d want 1/1", ok, rsp_cnt_b); end
  endtask

  task automatic test_invariants();
    n_vec++; if (viol_a != 0) begin n_err++; $display("FAIL inv_dut_a: got %0d violations want 0", viol_a); end
    n_vec++; if (viol_b != 0) begin n_err++; $display("FAIL inv_dut_b_mosi_stable: got %0d violations want 0", viol_b); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_midframe();
    test_clkdiv4();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
